register_sync_filt: RTL and testbench

- Parametrised successor to the team's 2/3/4-stage register synchroniser.
- Brings a multi-bit configuration or status word into the clk domain through a synchroniser chain of any depth from 2 to 8.
- A word-level stability filter follows the chain. It commits a value to the output only after the whole synchronised word has been constant for stable_cycles enabled cycles, so the output never shows a torn or glitched word.
- Used wherever OSD/config registers cross into the video or PLL domains.

---
 rtl/register_sync_filt.sv | 118 +++++++++++
 tb/tb_register_sync_filt.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_sync_filt.sv
// Multi-bit register synchroniser (2..8 stages) with word-level stability filter.
// Optional discarded-candidate counter: define REGSYNC_GLITCH_CNT_EN.
module register_sync_filt #(
  parameter int unsigned          reg_width     = 16,
  parameter logic [reg_width-1:0] reg_preset    = {reg_width{1'b0}},
  parameter int unsigned          resync_stages = 2,
  parameter int unsigned          stable_cycles = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clk_en,
  input  logic [reg_width-1:0] reg_i,
  output logic [reg_width-1:0] reg_o,
  output logic                 upd_o,
  output logic                 stable_o
`ifdef REGSYNC_GLITCH_CNT_EN
  ,
  input  logic                 glitch_clr_i,
  output logic [7:0]           glitch_cnt_o
`endif
);

  if (resync_stages < 2 || resync_stages > 8) begin : g_bad_stages
    $error("register_sync_filt: resync_stages must be 2..8");
  end
  if (reg_width < 1 || reg_width > 64) begin : g_bad_width
    $error("register_sync_filt: reg_width must be 1..64");
  end
  if (stable_cycles < 1 || stable_cycles > 255) begin : g_bad_stable
    $error("register_sync_filt: stable_cycles must be 1..255");
  end

  localparam int unsigned N  = resync_stages;
  localparam int unsigned CW = $clog2(stable_cycles + 1);
  localparam logic [CW-1:0] S  = CW'(stable_cycles);
  localparam logic [CW-1:0] S1 = CW'(stable_cycles - 1);

  logic [N-1:0][reg_width-1:0] s_q, s_d;
  logic [reg_width-1:0] sync_q;
  logic [reg_width-1:0] cand_q, cand_d;
  logic [reg_width-1:0] reg_q, reg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 upd_q, upd_d;

  assign sync_q = s_q[N-1];

  always_comb begin
    s_d = s_q;
    if (clk_en) begin
      s_d = {s_q[N-2:0], reg_i};
    end
  end

  // A sync_q change always restarts the filter, even on a commit edge.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    reg_d  = reg_q;
    upd_d  = 1'b0;
    if (clk_en) begin
      if (sync_q != cand_q) begin
        cand_d = sync_q;
        cnt_d  = '0;
      end else if (cnt_q == S1) begin
        reg_d = cand_q;
        cnt_d = S;
        upd_d = (cand_q != reg_q);
      end else if (cnt_q != S) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_q    <= {N{reg_preset}};
      cand_q <= reg_preset;
      reg_q  <= reg_preset;
      cnt_q  <= S;
      upd_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cand_q <= cand_d;
      reg_q  <= reg_d;
      cnt_q  <= cnt_d;
      upd_q  <= upd_d;
    end
  end

  assign reg_o    = reg_q;
  assign upd_o    = upd_q;
  assign stable_o = (cnt_q == S) && (cand_q == reg_q);

`ifdef REGSYNC_GLITCH_CNT_EN
  logic [7:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_clr_i) begin
      gcnt_d = '0;
    end else if (clk_en && (sync_q != cand_q) &&
                 (cand_q != reg_q) && (gcnt_q != 8'hFF)) begin
      gcnt_d = gcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign glitch_cnt_o = gcnt_q;
`endif

endmodule

// File: tb/tb_register_sync_filt.sv
// Directed self-checking bench for register_sync_filt.
// Four instances cover N/S/width/preset corners; glitch counter under REGSYNC_GLITCH_CNT_EN.
module tb_register_sync_filt;

  logic clk;
  logic nrst;
  logic clk_en;
  logic glitch_clr;

  logic [15:0] reg_i0, reg_o0;
  logic [15:0] reg_i1, reg_o1;
  logic [15:0] reg_i2, reg_o2;
  logic [63:0] reg_i3, reg_o3;
  logic upd0, upd1, upd2, upd3;
  logic stb0, stb1, stb2, stb3;
  logic [7:0] gc0, gc1, gc2, gc3;

  int checks;
  int failures;

  register_sync_filt #(
    .reg_width(16), .reg_preset(16'h0000),
    .resync_stages(2), .stable_cycles(3)
  ) u0 (
    .clk(clk), .nrst(nrst), .clk_en(clk_en),
    .reg_i(reg_i0), .reg_o(reg_o0),
    .upd_o(upd0), .stable_o(stb0)
`ifdef REGSYNC_GLITCH_CNT_EN
    , .glitch_clr_i(glitch_clr), .glitch_cnt_o(gc0)
`endif
  );

  register_sync_filt #(
    .reg_width(16), .reg_preset(16'h0000),
    .resync_stages(4), .stable_cycles(1)
  ) u1 (
    .clk(clk), .nrst(nrst), .clk_en(clk_en),
    .reg_i(reg_i1), .reg_o(reg_o1),
    .upd_o(upd1), .stable_o(stb1)
`ifdef REGSYNC_GLITCH_CNT_EN
    , .glitch_clr_i(glitch_clr), .glitch_cnt_o(gc1)
`endif
  );

  register_sync_filt #(
    .reg_width(16), .reg_preset(16'h0F0F),
    .resync_stages(2), .stable_cycles(3)
  ) u2 (
    .clk(clk), .nrst(nrst), .clk_en(clk_en),
    .reg_i(reg_i2), .reg_o(reg_o2),
    .upd_o(upd2), .stable_o(stb2)
`ifdef REGSYNC_GLITCH_CNT_EN
    , .glitch_clr_i(glitch_clr), .glitch_cnt_o(gc2)
`endif
  );

  register_sync_filt #(
    .reg_width(64), .reg_preset(64'h0),
    .resync_stages(8), .stable_cycles(255)
  ) u3 (
    .clk(clk), .nrst(nrst), .clk_en(clk_en),
    .reg_i(reg_i3), .reg_o(reg_o3),
    .upd_o(upd3), .stable_o(stb3)
`ifdef REGSYNC_GLITCH_CNT_EN
    , .glitch_clr_i(glitch_clr), .glitch_cnt_o(gc3)
`endif
  );

`ifndef REGSYNC_GLITCH_CNT_EN
  assign gc0 = '0;
  assign gc1 = '0;
  assign gc2 = '0;
  assign gc3 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reg_i0 = 16'h0000;
    reg_i1 = 16'h0000;
    reg_i2 = 16'h0F0F;
    reg_i3 = 64'h0;
    clk_en = 1'b1;
    glitch_clr = 1'b0;
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  logic seen;
  int   en_n;

  initial begin
    checks   = 0;
    failures = 0;
    do_reset();

    chk("rst_reg0", 64'(reg_o0), 64'h0);
    chk("rst_upd0", 64'(upd0), 64'h0);
    chk("rst_stb0", 64'(stb0), 64'h1);
    chk("rst_reg2", 64'(reg_o2), 64'h0F0F);
    chk("rst_gc0", 64'(gc0), 64'h0);

    // Basic latency: N=2, S=3 commits at edge 6.
    reg_i0 = 16'hA5C3;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("lat_reg_e%0d", e), 64'(reg_o0),
          (e >= 6) ? 64'hA5C3 : 64'h0);
      chk($sformatf("lat_upd_e%0d", e), 64'(upd0),
          (e == 6) ? 64'h1 : 64'h0);
      chk($sformatf("lat_stb_e%0d", e), 64'(stb0),
          (e >= 3 && e <= 5) ? 64'h0 : 64'h1);
    end

    // Short excursion 0 -> 00FF -> 0 is rejected.
    do_reset();
    reg_i0 = 16'h00FF;
    tick();
    tick();
    reg_i0 = 16'h0000;
    seen = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (upd0 || reg_o0 != 16'h0) seen = 1'b1;
    end
    chk("glitch_reject", 64'(seen), 64'h0);
    chk("glitch_reg0", 64'(reg_o0), 64'h0);
`ifdef REGSYNC_GLITCH_CNT_EN
    chk("glitch_cnt1", 64'(gc0), 64'h1);
`endif

    // N=4, S=1 with clk_en toggling: commit on 6th enabled edge.
    do_reset();
    reg_i1 = 16'h1234;
    en_n = 0;
    for (int i = 0; i < 14; i++) begin
      clk_en = (i % 2 == 0);
      tick();
      if (clk_en) en_n++;
      chk($sformatf("en_reg_i%0d", i), 64'(reg_o1),
          (en_n >= 6) ? 64'h1234 : 64'h0);
      chk($sformatf("en_upd_i%0d", i), 64'(upd1),
          (clk_en && en_n == 6) ? 64'h1 : 64'h0);
    end
    clk_en = 1'b1;

    // Reset mid-filter on preset 0x0F0F instance.
    do_reset();
    reg_i2 = 16'hBEEF;
    for (int e = 0; e < 4; e++) tick();
    chk("mid_stb_low", 64'(stb2), 64'h0);
    chk("mid_reg_hold", 64'(reg_o2), 64'h0F0F);
    reg_i2 = 16'h0F0F;
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_reg2", 64'(reg_o2), 64'h0F0F);
    chk("arst_upd2", 64'(upd2), 64'h0);
    chk("arst_stb2", 64'(stb2), 64'h1);
    tick();
    nrst = 1'b1;
    seen = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (upd2 || reg_o2 != 16'h0F0F || !stb2) seen = 1'b1;
    end
    chk("post_rst_quiet", 64'(seen), 64'h0);

`ifdef REGSYNC_GLITCH_CNT_EN
    // 300 one-cycle glitches saturate the counter; clear wins.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reg_i0 = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      tick();
    end
    chk("gc_sat", 64'(gc0), 64'hFF);
    chk("gc_reg_hold", 64'(reg_o0), 64'h0);
    reg_i0 = 16'h0001;
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    chk("gc_clr", 64'(gc0), 64'h0);
`endif

    // N=8, S=255, 64-bit: MSB change commits at edge 264.
    do_reset();
    reg_i3 = 64'h8000_0000_0000_0000;
    seen = 1'b0;
    for (int e = 1; e <= 270; e++) begin
      tick();
      if (reg_o3[62:0] != 63'h0) seen = 1'b1;
      if (e == 263) begin
        chk("wide_e263_reg", reg_o3, 64'h0);
        chk("wide_e263_upd", 64'(upd3), 64'h0);
      end
      if (e == 264) begin
        chk("wide_e264_reg", reg_o3, 64'h8000_0000_0000_0000);
        chk("wide_e264_upd", 64'(upd3), 64'h1);
      end
      if (e == 265) chk("wide_e265_upd", 64'(upd3), 64'h0);
    end
    chk("wide_low_bits", 64'(seen), 64'h0);
    chk("wide_stb", 64'(stb3), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
